// File: rtl/crc_frame_checker_if.sv
// Receive beat stream into crc_frame_checker.
//   axiid : DATA_W-bit data beat, bit 0 first on the wire
//   axiiv : beat valid; a frame is a contiguous run of axiiv=1
// master drives the stream (deserialiser side), slave consumes it (checker side).
interface crc_frame_checker_if #(
  parameter int unsigned DATA_W = 4
) ();
  logic [DATA_W-1:0] axiid;
  logic              axiiv;

  modport master (output axiid, output axiiv);
  modport slave  (input  axiid, input  axiiv);
endinterface

// File: rtl/crc_frame_checker.sv
// Ethernet FCS checker for the RX path. Folds DATA_W-bit beats into a reflected
// CRC-32 and checks the residue when a frame ends. It also flags runt and oversize
// frames, reports the frame length and keeps saturating good/bad frame counters.
//   clk, rst    : clock, asynchronous active-high reset
//   rx          : beat stream (axiid, axiiv), slave side
//   clr_cnt     : synchronous clear of good_cnt/bad_cnt; wins over a coincident done
//   done        : one-cycle pulse on the edge that samples the first axiiv=0
//   kill        : crc_err | runt | oversize of the last completed frame
//   crc_err     : residue mismatch
//   runt        : frame_beats < MIN_BEATS
//   oversize    : frame_beats > MAX_BEATS
//   frame_beats : beat count of the last completed frame
//   good_cnt    : frames ended with kill=0 (saturating)
//   bad_cnt     : frames ended with kill=1 (saturating)
// Status outputs hold until the next end of frame.
module crc_frame_checker #(
  parameter int unsigned DATA_W    = 4,
  parameter logic [31:0] RESIDUE   = 32'hDEBB20E3,
  parameter int unsigned MIN_BEATS = 128,
  parameter int unsigned MAX_BEATS = 3036,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  crc_frame_checker_if.slave   rx,
  input  logic                 clr_cnt,
  output logic                 done,
  output logic                 kill,
  output logic                 crc_err,
  output logic                 runt,
  output logic                 oversize,
  output logic [LEN_W-1:0]     frame_beats,
  output logic [CNT_W-1:0]     good_cnt,
  output logic [CNT_W-1:0]     bad_cnt
);

  localparam logic [31:0]      CrcPoly = 32'hEDB88320;
  localparam logic [31:0]      CrcInit = 32'hFFFFFFFF;
  localparam logic [LEN_W-1:0] LenMax  = '1;
  localparam logic [CNT_W-1:0] CntMax  = '1;

  if (!(DATA_W == 1 || DATA_W == 2 || DATA_W == 4 || DATA_W == 8)) begin : gen_bad_data_w
    $error("crc_frame_checker: DATA_W must be 1, 2, 4 or 8");
  end

  // A saturated length counter must still read as oversize.
  if ((LEN_W < 1) || (LEN_W > 32) ||
      (64'(MAX_BEATS) >= ((64'd1 << LEN_W) - 64'd1))) begin : gen_bad_len_w
    $error("crc_frame_checker: need LEN_W in 1..32 and MAX_BEATS < 2**LEN_W-1");
  end

  typedef enum logic {StIdle, StActive} state_e;

  state_e            state_q, state_d;
  logic [31:0]       crc_q, crc_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              eof;
  logic              crc_err_d, runt_d, oversize_d, kill_d;

  // Bit-serial reflected CRC-32, unrolled over one beat, axiid[0] first.
  function automatic logic [31:0] crc_fold(input logic [31:0] crc_in,
                                           input logic [DATA_W-1:0] d);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CrcPoly;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // crc_q is always CrcInit in StIdle, so the first beat folds into a fresh CRC.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    len_d   = len_q;
    eof     = 1'b0;
    case (state_q)
      StIdle: begin
        if (rx.axiiv) begin
          state_d = StActive;
          crc_d   = crc_fold(crc_q, rx.axiid);
          len_d   = LEN_W'(1);
        end
      end
      StActive: begin
        if (rx.axiiv) begin
          crc_d = crc_fold(crc_q, rx.axiid);
          if (len_q != LenMax) len_d = len_q + LEN_W'(1);
        end else begin
          eof     = 1'b1;
          crc_d   = CrcInit;
          len_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Verdict of the frame that ends this cycle.
  always_comb begin
    crc_err_d  = (crc_q != RESIDUE);
    runt_d     = (32'(len_q) < MIN_BEATS);
    oversize_d = (32'(len_q) > MAX_BEATS);
    kill_d     = crc_err_d | runt_d | oversize_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      crc_q   <= CrcInit;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      len_q   <= len_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done        <= 1'b0;
      kill        <= 1'b0;
      crc_err     <= 1'b0;
      runt        <= 1'b0;
      oversize    <= 1'b0;
      frame_beats <= '0;
    end else begin
      done <= eof;
      if (eof) begin
        kill        <= kill_d;
        crc_err     <= crc_err_d;
        runt        <= runt_d;
        oversize    <= oversize_d;
        frame_beats <= len_q;
      end
    end
  end

  // Counters move on the same edge as done; a clear drops a coincident frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (clr_cnt) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else if (eof) begin
      if (!kill_d && (good_cnt != CntMax)) good_cnt <= good_cnt + CNT_W'(1);
      if (kill_d && (bad_cnt != CntMax))   bad_cnt  <= bad_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
// Scoreboard bench for crc_frame_checker. Four instances cover DATA_W=8/4/2 with
// short minimum frames (the DATA_W=2 one with 2-bit counters) and DATA_W=4 with
// default limits. Frames are driven one at a time; the expected verdict is pushed
// when the frame's end is driven and popped when a done pulse is seen.
module tb_crc_frame_checker;

  localparam logic [31:0] Residue = 32'hDEBB20E3;
  localparam int          MaxBeats = 3036;

  typedef bit bit_q_t[$];

  typedef struct {
    int sel;
    int cyc;
    bit err;
    bit runt;
    bit over;
    int beats;
    int good;
    int bad;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_cnt = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_frame_checker_if #(.DATA_W(8)) if8 ();
  crc_frame_checker_if #(.DATA_W(4)) if4 ();
  crc_frame_checker_if #(.DATA_W(2)) if2 ();
  crc_frame_checker_if #(.DATA_W(4)) if4d ();

  logic [3:0]  done_s, kill_s, err_s, runt_s, over_s;
  logic [15:0] beats_s [4];
  logic [15:0] good8, bad8, good4, bad4, good4d, bad4d;
  logic [1:0]  good2, bad2;

  crc_frame_checker #(.DATA_W(8), .MIN_BEATS(4)) u_dut8 (
    .clk(clk), .rst(rst), .rx(if8), .clr_cnt(clr_cnt), .done(done_s[0]), .kill(kill_s[0]),
    .crc_err(err_s[0]), .runt(runt_s[0]), .oversize(over_s[0]), .frame_beats(beats_s[0]),
    .good_cnt(good8), .bad_cnt(bad8)
  );
  crc_frame_checker #(.DATA_W(4), .MIN_BEATS(4)) u_dut4 (
    .clk(clk), .rst(rst), .rx(if4), .clr_cnt(clr_cnt), .done(done_s[1]), .kill(kill_s[1]),
    .crc_err(err_s[1]), .runt(runt_s[1]), .oversize(over_s[1]), .frame_beats(beats_s[1]),
    .good_cnt(good4), .bad_cnt(bad4)
  );
  crc_frame_checker #(.DATA_W(2), .MIN_BEATS(4), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .rx(if2), .clr_cnt(clr_cnt), .done(done_s[2]), .kill(kill_s[2]),
    .crc_err(err_s[2]), .runt(runt_s[2]), .oversize(over_s[2]), .frame_beats(beats_s[2]),
    .good_cnt(good2), .bad_cnt(bad2)
  );
  crc_frame_checker #(.DATA_W(4)) u_dut4d (
    .clk(clk), .rst(rst), .rx(if4d), .clr_cnt(clr_cnt), .done(done_s[3]), .kill(kill_s[3]),
    .crc_err(err_s[3]), .runt(runt_s[3]), .oversize(over_s[3]), .frame_beats(beats_s[3]),
    .good_cnt(good4d), .bad_cnt(bad4d)
  );

  int   min_beats [4] = '{4, 4, 4, 128};
  int   cnt_max   [4] = '{65535, 65535, 3, 65535};
  int   exp_good  [4] = '{0, 0, 0, 0};
  int   exp_bad   [4] = '{0, 0, 0, 0};
  exp_t exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] obs_good(input int s);
    case (s)
      0:       return good8;
      1:       return good4;
      2:       return {14'd0, good2};
      default: return good4d;
    endcase
  endfunction

  function automatic logic [15:0] obs_bad(input int s);
    case (s)
      0:       return bad8;
      1:       return bad4;
      2:       return {14'd0, bad2};
      default: return bad4d;
    endcase
  endfunction

  // Reference: bit-serial reflected CRC-32, no final XOR.
  function automatic logic [31:0] crc_ref(input bit_q_t bs);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (bs[i]) begin
      if (c[0] ^ bs[i]) c = (c >> 1) ^ 32'hEDB88320;
      else              c = c >> 1;
    end
    return c;
  endfunction

  function automatic bit_q_t rand_bits(input int n);
    bit_q_t q;
    for (int i = 0; i < n; i++) q.push_back(bit'($urandom_range(0, 1)));
    return q;
  endfunction

  task automatic drive_beat(input int s, input logic [7:0] d, input logic v);
    case (s)
      0:       begin if8.axiid  = d;      if8.axiiv  = v; end
      1:       begin if4.axiid  = d[3:0]; if4.axiiv  = v; end
      2:       begin if2.axiid  = d[1:0]; if2.axiiv  = v; end
      default: begin if4d.axiid = d[3:0]; if4d.axiiv = v; end
    endcase
  endtask

  // Called just after a clock edge; returns just after the edge following the
  // end-of-frame cycle, so calls back to back leave exactly one idle cycle.
  task automatic send_frame(input int s, input int w, input bit_q_t bs, input bit clr);
    int          n;
    logic [7:0]  d;
    logic [31:0] c;
    exp_t        e;
    n = bs.size() / w;
    for (int j = 0; j < n; j++) begin
      d = '0;
      for (int k = 0; k < w; k++) d[k] = bs[j*w + k];
      drive_beat(s, d, 1'b1);
      @(posedge clk); #1;
    end
    drive_beat(s, 8'h00, 1'b0);
    clr_cnt = clr;
    c      = crc_ref(bs);
    e.sel  = s;
    e.cyc  = cyc + 1;
    e.err  = (c != Residue);
    e.runt = (n < min_beats[s]);
    e.over = (n > MaxBeats);
    e.beats = n;
    if (clr) begin
      for (int i = 0; i < 4; i++) begin exp_good[i] = 0; exp_bad[i] = 0; end
    end else if (e.err || e.runt || e.over) begin
      if (exp_bad[s] < cnt_max[s]) exp_bad[s]++;
    end else begin
      if (exp_good[s] < cnt_max[s]) exp_good[s]++;
    end
    e.good = exp_good[s];
    e.bad  = exp_bad[s];
    exp_q.push_back(e);
    @(posedge clk); #1;
    clr_cnt = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    #1;
  endtask

  task automatic check_zero(input int s);
    check("zero_done",  done_s[s], 1'b0);
    check("zero_kill",  kill_s[s], 1'b0);
    check("zero_err",   err_s[s],  1'b0);
    check("zero_runt",  runt_s[s], 1'b0);
    check("zero_over",  over_s[s], 1'b0);
    check("zero_beats", beats_s[s], 16'd0);
    check("zero_good",  obs_good(s), 16'd0);
    check("zero_bad",   obs_bad(s),  16'd0);
  endtask

  // Scoreboard consumer.
  logic [3:0] prev_done = '0;
  always @(negedge clk) begin
    exp_t e;
    for (int s = 0; s < 4; s++) begin
      if (done_s[s] === 1'b1) begin
        if (prev_done[s]) check("done_width", 1'b1, 1'b0);
        if (exp_q.size() == 0) begin
          check("spurious_done", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("sb_instance", 64'(s), 64'(e.sel));
          check("done_cycle",  64'(cyc), 64'(e.cyc));
          check("crc_err",     err_s[s],  e.err);
          check("runt",        runt_s[s], e.runt);
          check("oversize",    over_s[s], e.over);
          check("kill",        kill_s[s], e.err | e.runt | e.over);
          check("frame_beats", beats_s[s], 16'(e.beats));
          check("good_cnt",    obs_good(s), 16'(e.good));
          check("bad_cnt",     obs_bad(s),  16'(e.bad));
        end
      end
    end
    prev_done <= done_s;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit [7:0] std_bytes [13];
    bit_q_t   std_bits;
    bit_q_t   bad_bits;
    bit_q_t   one_bits;
    logic [7:0] b;

    std_bytes = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                  8'h26, 8'h39, 8'hF4, 8'hCB};
    for (int i = 0; i < 13; i++) begin
      b = std_bytes[i];
      for (int k = 0; k < 8; k++) std_bits.push_back(b[k]);
      if (i == 2) b = 8'h35;
      for (int k = 0; k < 8; k++) bad_bits.push_back(b[k]);
    end
    b = 8'hA5;
    for (int k = 0; k < 8; k++) one_bits.push_back(b[k]);

    for (int s = 0; s < 4; s++) drive_beat(s, 8'h00, 1'b0);

    // Reset state
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) check_zero(s);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Known-good frame, then a corrupted one
    send_frame(0, 8, std_bits, 1'b0);
    drain();
    send_frame(0, 8, bad_bits, 1'b0);
    drain();
    repeat (3) @(negedge clk);
    check("kill_hold", kill_s[0], 1'b1);
    check("err_hold",  err_s[0],  1'b1);
    check("beats_hold", beats_s[0], 16'd13);
    @(posedge clk); #1;

    // Width independence
    send_frame(1, 4, std_bits, 1'b0);
    drain();
    send_frame(2, 2, std_bits, 1'b0);
    drain();

    // Back-to-back with a single idle cycle
    send_frame(0, 8, std_bits, 1'b0);
    send_frame(0, 8, std_bits, 1'b0);
    drain();

    // One-beat frame
    send_frame(0, 8, one_bits, 1'b0);
    drain();

    // Length limits at default parameters
    send_frame(3, 4, rand_bits(20 * 4), 1'b0);
    drain();
    send_frame(3, 4, rand_bits(128 * 4), 1'b0);
    drain();
    send_frame(3, 4, rand_bits(3036 * 4), 1'b0);
    drain();
    send_frame(3, 4, rand_bits(3040 * 4), 1'b0);
    drain();

    // Reset in the middle of a frame: discarded, everything zero
    for (int j = 0; j < 6; j++) begin
      drive_beat(0, std_bytes[j], 1'b1);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    drive_beat(0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin exp_good[i] = 0; exp_bad[i] = 0; end
    @(negedge clk);
    for (int s = 0; s < 4; s++) check_zero(s);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_zero(0);

    // Clear coincident with done: the frame is not counted
    send_frame(0, 8, std_bits, 1'b1);
    drain();
    check("clr_good", good8, 16'd0);
    check("clr_bad",  bad8,  16'd0);

    // 2-bit counters saturate
    for (int i = 0; i < 5; i++) begin
      send_frame(2, 2, std_bits, 1'b0);
      drain();
    end
    check("sat_good2", good2, 2'd3);
    check("sat_bad2",  bad2,  2'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
